// File: rtl/ysyx_24110006_axi_arbiter_pkg.sv
// Shared types and AXI constants for the IFU/LSU memory-bus arbiter.
package ysyx_24110006_axi_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIfuRd = 2'd1,
    StLsuRd = 2'd2,
    StLsuWr = 2'd3
  } arb_state_e;

  typedef enum logic {
    GrantIfu = 1'b0,
    GrantLsu = 1'b1
  } grant_e;

  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/ysyx_24110006_arb_prio.sv
// Grant decision: picks the next owner from the pending requests and the last grant.
module ysyx_24110006_arb_prio
  import ysyx_24110006_axi_arbiter_pkg::*;
#(
  parameter int unsigned FAIR = 1
) (
  input  logic       req_ifu_i,
  input  logic       req_lsu_r_i,
  input  logic       req_lsu_w_i,
  input  grant_e     last_grant_i,
  output arb_state_e grant_state_o
);

  arb_state_e lsu_state;
  logic       req_lsu;
  logic       lsu_first;

  // Writes beat reads inside the LSU so stores drain before dependent loads.
  assign lsu_state = req_lsu_w_i ? StLsuWr : StLsuRd;
  assign req_lsu   = req_lsu_r_i | req_lsu_w_i;
  assign lsu_first = (FAIR == 0) || (last_grant_i == GrantIfu);

  always_comb begin
    grant_state_o = StIdle;
    if (req_ifu_i && req_lsu) begin
      grant_state_o = lsu_first ? lsu_state : StIfuRd;
    end else if (req_ifu_i) begin
      grant_state_o = StIfuRd;
    end else if (req_lsu) begin
      grant_state_o = lsu_state;
    end
  end

endmodule

// File: rtl/ysyx_24110006_axi_arbiter.sv
// Two-master AXI arbiter: IFU reads and LSU reads/writes share one slave bus.
module ysyx_24110006_axi_arbiter
  import ysyx_24110006_axi_arbiter_pkg::*;
#(
  parameter int unsigned FAIR = 1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_m0_araddr,
  input  logic        i_m0_arvalid,
  input  logic [3:0]  i_m0_arid,
  input  logic [7:0]  i_m0_arlen,
  input  logic [2:0]  i_m0_arsize,
  input  logic [1:0]  i_m0_arburst,
  output logic        o_m0_arready,
  output logic [31:0] o_m0_rdata,
  output logic        o_m0_rvalid,
  output logic [1:0]  o_m0_rresp,
  output logic [3:0]  o_m0_rid,
  output logic        o_m0_rlast,
  input  logic        i_m0_rready,
  input  logic [31:0] i_m1_araddr,
  input  logic        i_m1_arvalid,
  input  logic [3:0]  i_m1_arid,
  input  logic [7:0]  i_m1_arlen,
  input  logic [2:0]  i_m1_arsize,
  input  logic [1:0]  i_m1_arburst,
  output logic        o_m1_arready,
  output logic [31:0] o_m1_rdata,
  output logic        o_m1_rvalid,
  output logic [1:0]  o_m1_rresp,
  output logic [3:0]  o_m1_rid,
  output logic        o_m1_rlast,
  input  logic        i_m1_rready,
  input  logic [31:0] i_m1_awaddr,
  input  logic        i_m1_awvalid,
  input  logic [3:0]  i_m1_awid,
  input  logic [7:0]  i_m1_awlen,
  input  logic [2:0]  i_m1_awsize,
  input  logic [1:0]  i_m1_awburst,
  output logic        o_m1_awready,
  input  logic [31:0] i_m1_wdata,
  input  logic [3:0]  i_m1_wstrb,
  input  logic        i_m1_wvalid,
  input  logic        i_m1_wlast,
  output logic        o_m1_wready,
  output logic        o_m1_bvalid,
  output logic [1:0]  o_m1_bresp,
  output logic [3:0]  o_m1_bid,
  input  logic        i_m1_bready,
  output logic [31:0] o_s_araddr,
  output logic        o_s_arvalid,
  output logic [3:0]  o_s_arid,
  output logic [7:0]  o_s_arlen,
  output logic [2:0]  o_s_arsize,
  output logic [1:0]  o_s_arburst,
  input  logic        i_s_arready,
  input  logic [31:0] i_s_rdata,
  input  logic        i_s_rvalid,
  input  logic [1:0]  i_s_rresp,
  input  logic [3:0]  i_s_rid,
  input  logic        i_s_rlast,
  output logic        o_s_rready,
  output logic [31:0] o_s_awaddr,
  output logic        o_s_awvalid,
  output logic [3:0]  o_s_awid,
  output logic [7:0]  o_s_awlen,
  output logic [2:0]  o_s_awsize,
  output logic [1:0]  o_s_awburst,
  input  logic        i_s_awready,
  output logic [31:0] o_s_wdata,
  output logic [3:0]  o_s_wstrb,
  output logic        o_s_wvalid,
  output logic        o_s_wlast,
  input  logic        i_s_wready,
  input  logic        i_s_bvalid,
  input  logic [1:0]  i_s_bresp,
  input  logic [3:0]  i_s_bid,
  output logic        o_s_bready
);

  arb_state_e state_q, state_d, prio_state;
  grant_e     last_grant_q, last_grant_d;

  ysyx_24110006_arb_prio #(
    .FAIR(FAIR)
  ) u_prio (
    .req_ifu_i    (i_m0_arvalid),
    .req_lsu_r_i  (i_m1_arvalid),
    .req_lsu_w_i  (i_m1_awvalid),
    .last_grant_i (last_grant_q),
    .grant_state_o(prio_state)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q      <= StIdle;
      last_grant_q <= GrantIfu;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        state_d = prio_state;
        if (prio_state == StIfuRd) begin
          last_grant_d = GrantIfu;
        end else if (prio_state != StIdle) begin
          last_grant_d = GrantLsu;
        end
      end
      StIfuRd, StLsuRd: if (i_s_rvalid && o_s_rready && i_s_rlast) state_d = StIdle;
      StLsuWr:          if (i_s_bvalid && o_s_bready) state_d = StIdle;
      default:          state_d = StIdle;
    endcase
  end

  // Owner's channels pass straight through; everything else stays at zero.
  always_comb begin
    o_m0_arready = 1'b0;  o_m0_rdata = '0;     o_m0_rvalid = 1'b0;
    o_m0_rresp   = '0;    o_m0_rid   = '0;     o_m0_rlast  = 1'b0;
    o_m1_arready = 1'b0;  o_m1_rdata = '0;     o_m1_rvalid = 1'b0;
    o_m1_rresp   = '0;    o_m1_rid   = '0;     o_m1_rlast  = 1'b0;
    o_m1_awready = 1'b0;  o_m1_wready = 1'b0;  o_m1_bvalid = 1'b0;
    o_m1_bresp   = '0;    o_m1_bid    = '0;
    o_s_araddr   = '0;    o_s_arvalid = 1'b0;  o_s_arid    = '0;
    o_s_arlen    = '0;    o_s_arsize  = '0;    o_s_arburst = '0;
    o_s_rready   = 1'b0;
    o_s_awaddr   = '0;    o_s_awvalid = 1'b0;  o_s_awid    = '0;
    o_s_awlen    = '0;    o_s_awsize  = '0;    o_s_awburst = '0;
    o_s_wdata    = '0;    o_s_wstrb   = '0;    o_s_wvalid  = 1'b0;
    o_s_wlast    = 1'b0;  o_s_bready  = 1'b0;
    unique case (state_q)
      StIfuRd: begin
        o_s_araddr  = i_m0_araddr;  o_s_arvalid = i_m0_arvalid; o_s_arid    = i_m0_arid;
        o_s_arlen   = i_m0_arlen;   o_s_arsize  = i_m0_arsize;  o_s_arburst = i_m0_arburst;
        o_m0_arready = i_s_arready;
        o_m0_rdata  = i_s_rdata;    o_m0_rvalid = i_s_rvalid;   o_m0_rresp  = i_s_rresp;
        o_m0_rid    = i_s_rid;      o_m0_rlast  = i_s_rlast;
        o_s_rready  = i_m0_rready;
      end
      StLsuRd: begin
        o_s_araddr  = i_m1_araddr;  o_s_arvalid = i_m1_arvalid; o_s_arid    = i_m1_arid;
        o_s_arlen   = i_m1_arlen;   o_s_arsize  = i_m1_arsize;  o_s_arburst = i_m1_arburst;
        o_m1_arready = i_s_arready;
        o_m1_rdata  = i_s_rdata;    o_m1_rvalid = i_s_rvalid;   o_m1_rresp  = i_s_rresp;
        o_m1_rid    = i_s_rid;      o_m1_rlast  = i_s_rlast;
        o_s_rready  = i_m1_rready;
      end
      StLsuWr: begin
        o_s_awaddr  = i_m1_awaddr;  o_s_awvalid = i_m1_awvalid; o_s_awid    = i_m1_awid;
        o_s_awlen   = i_m1_awlen;   o_s_awsize  = i_m1_awsize;  o_s_awburst = i_m1_awburst;
        o_m1_awready = i_s_awready;
        o_s_wdata   = i_m1_wdata;   o_s_wstrb   = i_m1_wstrb;   o_s_wvalid  = i_m1_wvalid;
        o_s_wlast   = i_m1_wlast;   o_m1_wready = i_s_wready;
        o_m1_bvalid = i_s_bvalid;   o_m1_bresp  = i_s_bresp;    o_m1_bid    = i_s_bid;
        o_s_bready  = i_m1_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24110006_axi_arbiter.sv
// Directed bench for the AXI arbiter: FAIR=1 and FAIR=0 instances share one stimulus.
module tb_ysyx_24110006_axi_arbiter;
  import ysyx_24110006_axi_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] i_m0_araddr, i_m1_araddr, i_m1_awaddr, i_m1_wdata, i_s_rdata;
  logic        i_m0_arvalid, i_m1_arvalid, i_m1_awvalid, i_m1_wvalid, i_m1_wlast;
  logic [3:0]  i_m0_arid, i_m1_arid, i_m1_awid, i_m1_wstrb, i_s_rid, i_s_bid;
  logic [7:0]  i_m0_arlen, i_m1_arlen, i_m1_awlen;
  logic [2:0]  i_m0_arsize, i_m1_arsize, i_m1_awsize;
  logic [1:0]  i_m0_arburst, i_m1_arburst, i_m1_awburst, i_s_rresp, i_s_bresp;
  logic        i_m0_rready, i_m1_rready, i_m1_bready;
  logic        i_s_arready, i_s_awready, i_s_wready, i_s_rvalid, i_s_rlast, i_s_bvalid;

  // FAIR=1 instance outputs
  logic [31:0] o_m0_rdata, o_m1_rdata, o_s_araddr, o_s_awaddr, o_s_wdata;
  logic        o_m0_arready, o_m0_rvalid, o_m0_rlast, o_m1_arready, o_m1_rvalid, o_m1_rlast;
  logic        o_m1_awready, o_m1_wready, o_m1_bvalid, o_s_arvalid, o_s_awvalid;
  logic        o_s_wvalid, o_s_wlast, o_s_rready, o_s_bready;
  logic [1:0]  o_m0_rresp, o_m1_rresp, o_m1_bresp, o_s_arburst, o_s_awburst;
  logic [3:0]  o_m0_rid, o_m1_rid, o_m1_bid, o_s_arid, o_s_awid, o_s_wstrb;
  logic [7:0]  o_s_arlen, o_s_awlen;
  logic [2:0]  o_s_arsize, o_s_awsize;

  // FAIR=0 instance outputs
  logic [31:0] z_m0_rdata, z_m1_rdata, z_s_araddr, z_s_awaddr, z_s_wdata;
  logic        z_m0_arready, z_m0_rvalid, z_m0_rlast, z_m1_arready, z_m1_rvalid, z_m1_rlast;
  logic        z_m1_awready, z_m1_wready, z_m1_bvalid, z_s_arvalid, z_s_awvalid;
  logic        z_s_wvalid, z_s_wlast, z_s_rready, z_s_bready;
  logic [1:0]  z_m0_rresp, z_m1_rresp, z_m1_bresp, z_s_arburst, z_s_awburst;
  logic [3:0]  z_m0_rid, z_m1_rid, z_m1_bid, z_s_arid, z_s_awid, z_s_wstrb;
  logic [7:0]  z_s_arlen, z_s_awlen;
  logic [2:0]  z_s_arsize, z_s_awsize;

  ysyx_24110006_axi_arbiter #(.FAIR(1)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_m0_araddr(i_m0_araddr), .i_m0_arvalid(i_m0_arvalid), .i_m0_arid(i_m0_arid),
    .i_m0_arlen(i_m0_arlen), .i_m0_arsize(i_m0_arsize), .i_m0_arburst(i_m0_arburst),
    .o_m0_arready(o_m0_arready), .o_m0_rdata(o_m0_rdata), .o_m0_rvalid(o_m0_rvalid),
    .o_m0_rresp(o_m0_rresp), .o_m0_rid(o_m0_rid), .o_m0_rlast(o_m0_rlast),
    .i_m0_rready(i_m0_rready),
    .i_m1_araddr(i_m1_araddr), .i_m1_arvalid(i_m1_arvalid), .i_m1_arid(i_m1_arid),
    .i_m1_arlen(i_m1_arlen), .i_m1_arsize(i_m1_arsize), .i_m1_arburst(i_m1_arburst),
    .o_m1_arready(o_m1_arready), .o_m1_rdata(o_m1_rdata), .o_m1_rvalid(o_m1_rvalid),
    .o_m1_rresp(o_m1_rresp), .o_m1_rid(o_m1_rid), .o_m1_rlast(o_m1_rlast),
    .i_m1_rready(i_m1_rready),
    .i_m1_awaddr(i_m1_awaddr), .i_m1_awvalid(i_m1_awvalid), .i_m1_awid(i_m1_awid),
    .i_m1_awlen(i_m1_awlen), .i_m1_awsize(i_m1_awsize), .i_m1_awburst(i_m1_awburst),
    .o_m1_awready(o_m1_awready), .i_m1_wdata(i_m1_wdata), .i_m1_wstrb(i_m1_wstrb),
    .i_m1_wvalid(i_m1_wvalid), .i_m1_wlast(i_m1_wlast), .o_m1_wready(o_m1_wready),
    .o_m1_bvalid(o_m1_bvalid), .o_m1_bresp(o_m1_bresp), .o_m1_bid(o_m1_bid),
    .i_m1_bready(i_m1_bready),
    .o_s_araddr(o_s_araddr), .o_s_arvalid(o_s_arvalid), .o_s_arid(o_s_arid),
    .o_s_arlen(o_s_arlen), .o_s_arsize(o_s_arsize), .o_s_arburst(o_s_arburst),
    .i_s_arready(i_s_arready), .i_s_rdata(i_s_rdata), .i_s_rvalid(i_s_rvalid),
    .i_s_rresp(i_s_rresp), .i_s_rid(i_s_rid), .i_s_rlast(i_s_rlast), .o_s_rready(o_s_rready),
    .o_s_awaddr(o_s_awaddr), .o_s_awvalid(o_s_awvalid), .o_s_awid(o_s_awid),
    .o_s_awlen(o_s_awlen), .o_s_awsize(o_s_awsize), .o_s_awburst(o_s_awburst),
    .i_s_awready(i_s_awready), .o_s_wdata(o_s_wdata), .o_s_wstrb(o_s_wstrb),
    .o_s_wvalid(o_s_wvalid), .o_s_wlast(o_s_wlast), .i_s_wready(i_s_wready),
    .i_s_bvalid(i_s_bvalid), .i_s_bresp(i_s_bresp), .i_s_bid(i_s_bid), .o_s_bready(o_s_bready)
  );

  ysyx_24110006_axi_arbiter #(.FAIR(0)) dut_f0 (
    .i_clock(clk), .i_reset(rst_n),
    .i_m0_araddr(i_m0_araddr), .i_m0_arvalid(i_m0_arvalid), .i_m0_arid(i_m0_arid),
    .i_m0_arlen(i_m0_arlen), .i_m0_arsize(i_m0_arsize), .i_m0_arburst(i_m0_arburst),
    .o_m0_arready(z_m0_arready), .o_m0_rdata(z_m0_rdata), .o_m0_rvalid(z_m0_rvalid),
    .o_m0_rresp(z_m0_rresp), .o_m0_rid(z_m0_rid), .o_m0_rlast(z_m0_rlast),
    .i_m0_rready(i_m0_rready),
    .i_m1_araddr(i_m1_araddr), .i_m1_arvalid(i_m1_arvalid), .i_m1_arid(i_m1_arid),
    .i_m1_arlen(i_m1_arlen), .i_m1_arsize(i_m1_arsize), .i_m1_arburst(i_m1_arburst),
    .o_m1_arready(z_m1_arready), .o_m1_rdata(z_m1_rdata), .o_m1_rvalid(z_m1_rvalid),
    .o_m1_rresp(z_m1_rresp), .o_m1_rid(z_m1_rid), .o_m1_rlast(z_m1_rlast),
    .i_m1_rready(i_m1_rready),
    .i_m1_awaddr(i_m1_awaddr), .i_m1_awvalid(i_m1_awvalid), .i_m1_awid(i_m1_awid),
    .i_m1_awlen(i_m1_awlen), .i_m1_awsize(i_m1_awsize), .i_m1_awburst(i_m1_awburst),
    .o_m1_awready(z_m1_awready), .i_m1_wdata(i_m1_wdata), .i_m1_wstrb(i_m1_wstrb),
    .i_m1_wvalid(i_m1_wvalid), .i_m1_wlast(i_m1_wlast), .o_m1_wready(z_m1_wready),
    .o_m1_bvalid(z_m1_bvalid), .o_m1_bresp(z_m1_bresp), .o_m1_bid(z_m1_bid),
    .i_m1_bready(i_m1_bready),
    .o_s_araddr(z_s_araddr), .o_s_arvalid(z_s_arvalid), .o_s_arid(z_s_arid),
    .o_s_arlen(z_s_arlen), .o_s_arsize(z_s_arsize), .o_s_arburst(z_s_arburst),
    .i_s_arready(i_s_arready), .i_s_rdata(i_s_rdata), .i_s_rvalid(i_s_rvalid),
    .i_s_rresp(i_s_rresp), .i_s_rid(i_s_rid), .i_s_rlast(i_s_rlast), .o_s_rready(z_s_rready),
    .o_s_awaddr(z_s_awaddr), .o_s_awvalid(z_s_awvalid), .o_s_awid(z_s_awid),
    .o_s_awlen(z_s_awlen), .o_s_awsize(z_s_awsize), .o_s_awburst(z_s_awburst),
    .i_s_awready(i_s_awready), .o_s_wdata(z_s_wdata), .o_s_wstrb(z_s_wstrb),
    .o_s_wvalid(z_s_wvalid), .o_s_wlast(z_s_wlast), .i_s_wready(i_s_wready),
    .i_s_bvalid(i_s_bvalid), .i_s_bresp(i_s_bresp), .i_s_bid(i_s_bid), .o_s_bready(z_s_bready)
  );

  logic any_out;
  assign any_out = |{o_m0_arready, o_m0_rdata, o_m0_rvalid, o_m0_rresp, o_m0_rid, o_m0_rlast,
                     o_m1_arready, o_m1_rdata, o_m1_rvalid, o_m1_rresp, o_m1_rid, o_m1_rlast,
                     o_m1_awready, o_m1_wready, o_m1_bvalid, o_m1_bresp, o_m1_bid,
                     o_s_araddr, o_s_arvalid, o_s_arid, o_s_arlen, o_s_arsize, o_s_arburst,
                     o_s_rready, o_s_awaddr, o_s_awvalid, o_s_awid, o_s_awlen, o_s_awsize,
                     o_s_awburst, o_s_wdata, o_s_wstrb, o_s_wvalid, o_s_wlast, o_s_bready};

  int n_tests = 0;
  int n_fail  = 0;
  logic mon_en = 1'b0;

  // Owner seen on the outputs: 0 idle, 1 IFU read, 2 LSU read, 3 LSU write.
  // Relies on all master rready/bready held at 1 and IFU arid=1, LSU arid=2.
  function automatic int owner(input logic bready, input logic rready, input logic [3:0] arid);
    if (bready) return 3;
    if (rready) return (arid == 4'd1) ? 1 : 2;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_m0_arvalid = 1'b0; i_m1_arvalid = 1'b0; i_m1_awvalid = 1'b0;
    i_m1_wvalid  = 1'b0; i_m1_wlast   = 1'b0;
    i_s_rvalid   = 1'b0; i_s_rlast    = 1'b0; i_s_bvalid   = 1'b0;
  endtask

  // Non-owner isolation and single address valid, checked every cycle.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      int own;
      logic bad;
      own = owner(o_s_bready, o_s_rready, o_s_arid);
      bad = (o_s_arvalid && o_s_awvalid);
      if (own != 1) bad = bad | o_m0_arready | o_m0_rvalid;
      if (own != 2) bad = bad | o_m1_arready | o_m1_rvalid;
      if (own != 3) bad = bad | o_m1_awready | o_m1_wready | o_m1_bvalid;
      if (own != 3) bad = bad | o_s_awvalid | o_s_wvalid;
      chk($sformatf("isolation owner=%0d", own), {31'd0, bad}, 32'd0);
    end
  end

  typedef struct {
    logic [6:0] stim;   // {rst_n, m0_arvalid, m1_arvalid, m1_awvalid, s_rvalid, s_rlast, s_bvalid}
    int         exp1;   // owner after edge, FAIR=1
    int         exp0;   // owner after edge, FAIR=0
    logic       exp_arv;
  } vec_t;

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{7'b0000000, 0, 0, 1'b0};
    vecs[1]  = '{7'b1100000, 1, 1, 1'b1};
    vecs[2]  = '{7'b1000100, 1, 1, 1'b0};
    vecs[3]  = '{7'b1000110, 0, 0, 1'b0};
    vecs[4]  = '{7'b1110000, 2, 2, 1'b1};
    vecs[5]  = '{7'b1110110, 0, 0, 1'b0};
    vecs[6]  = '{7'b1110000, 1, 2, 1'b1};
    vecs[7]  = '{7'b1110110, 0, 0, 1'b0};
    vecs[8]  = '{7'b1011000, 3, 3, 1'b0};
    vecs[9]  = '{7'b1000001, 0, 0, 1'b0};
    vecs[10] = '{7'b1010000, 2, 2, 1'b1};
    vecs[11] = '{7'b1011000, 2, 2, 1'b1};
    vecs[12] = '{7'b1001110, 0, 0, 1'b0};
    vecs[13] = '{7'b1001000, 3, 3, 1'b0};
    vecs[14] = '{7'b0001000, 0, 0, 1'b0};
    vecs[15] = '{7'b1000000, 0, 0, 1'b0};
    vecs[16] = '{7'b1110000, 2, 2, 1'b1};
    vecs[17] = '{7'b1110100, 2, 2, 1'b1};

    rst_n = 1'b0;
    idle_inputs();
    i_m0_araddr = 32'h8000_0000; i_m0_arid = 4'd1; i_m0_arlen = 8'd0;
    i_m0_arsize = SIZE_WORD;     i_m0_arburst = BURST_INCR;
    i_m1_araddr = 32'h8000_0200; i_m1_arid = 4'd2; i_m1_arlen = 8'd0;
    i_m1_arsize = SIZE_WORD;     i_m1_arburst = BURST_INCR;
    i_m1_awaddr = 32'h8000_0100; i_m1_awid = 4'd2; i_m1_awlen = 8'd0;
    i_m1_awsize = SIZE_WORD;     i_m1_awburst = BURST_INCR;
    i_m1_wdata  = 32'h0;         i_m1_wstrb = 4'h0;
    i_m0_rready = 1'b1; i_m1_rready = 1'b1; i_m1_bready = 1'b1;
    i_s_arready = 1'b1; i_s_awready = 1'b1; i_s_wready = 1'b1;
    i_s_rdata = 32'h0; i_s_rresp = RESP_OKAY; i_s_rid = 4'd0;
    i_s_bresp = 2'b10; i_s_bid = 4'd0;
    #2;

    // Table: arbitration, fairness, write-over-read, no preemption, reset of last grant.
    for (int i = 0; i < 18; i++) begin
      rst_n        = vecs[i].stim[6];
      i_m0_arvalid = vecs[i].stim[5];
      i_m1_arvalid = vecs[i].stim[4];
      i_m1_awvalid = vecs[i].stim[3];
      i_s_rvalid   = vecs[i].stim[2];
      i_s_rlast    = vecs[i].stim[1];
      i_s_bvalid   = vecs[i].stim[0];
      tick();
      mon_en = 1'b1;
      chk($sformatf("vec%0d owner fair1", i), owner(o_s_bready, o_s_rready, o_s_arid),
          vecs[i].exp1);
      chk($sformatf("vec%0d owner fair0", i), owner(z_s_bready, z_s_rready, z_s_arid),
          vecs[i].exp0);
      chk($sformatf("vec%0d s_arvalid", i), {31'd0, o_s_arvalid}, {31'd0, vecs[i].exp_arv});
    end

    // IFU-only read, data returned three cycles after the address handshake.
    idle_inputs();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    i_m0_araddr = 32'h8000_0000; i_m0_arvalid = 1'b1;
    #1;
    chk("A idle no comb path", {31'd0, o_s_arvalid}, 32'd0);
    tick();
    chk("A s_arvalid", {31'd0, o_s_arvalid}, 32'd1);
    chk("A s_araddr", o_s_araddr, 32'h8000_0000);
    chk("A m0_arready", {31'd0, o_m0_arready}, 32'd1);
    tick();
    i_m0_arvalid = 1'b0;
    tick(); tick();
    i_s_rdata = 32'hDEAD_BEEF; i_s_rid = 4'd1; i_s_rvalid = 1'b1; i_s_rlast = 1'b1;
    #1;
    chk("A m0_rdata", o_m0_rdata, 32'hDEAD_BEEF);
    chk("A m0_rvalid/rlast", {30'd0, o_m0_rvalid, o_m0_rlast}, 32'd3);
    tick();
    idle_inputs();
    #1;
    chk("A back to idle", owner(o_s_bready, o_s_rready, o_s_arid), 0);
    chk("A m0_rvalid low", {31'd0, o_m0_rvalid}, 32'd0);

    // LSU write and read together: write first, OKAY response, one idle cycle, then read.
    i_m1_awaddr = 32'h8000_0100; i_m1_awvalid = 1'b1;
    i_m1_wdata = 32'h1234_5678; i_m1_wstrb = 4'hF; i_m1_wvalid = 1'b1; i_m1_wlast = 1'b1;
    i_m1_araddr = 32'h8000_0200; i_m1_arvalid = 1'b1;
    tick();
    chk("B owner write", owner(o_s_bready, o_s_rready, o_s_arid), 3);
    chk("B s_awaddr", o_s_awaddr, 32'h8000_0100);
    chk("B s_wdata", o_s_wdata, 32'h1234_5678);
    chk("B s_wstrb", {28'd0, o_s_wstrb}, 32'hF);
    chk("B s_arvalid held", {31'd0, o_s_arvalid}, 32'd0);
    chk("B m1_awready/wready", {30'd0, o_m1_awready, o_m1_wready}, 32'd3);
    tick();
    i_m1_awvalid = 1'b0; i_m1_wvalid = 1'b0; i_m1_wlast = 1'b0;
    i_s_bvalid = 1'b1; i_s_bresp = RESP_OKAY; i_s_bid = 4'd2;
    #1;
    chk("B m1_bvalid", {31'd0, o_m1_bvalid}, 32'd1);
    chk("B m1_bresp", {30'd0, o_m1_bresp}, {30'd0, RESP_OKAY});
    chk("B m1_bid", {28'd0, o_m1_bid}, 32'd2);
    tick();
    i_s_bvalid = 1'b0; i_s_bresp = 2'b10;
    #1;
    chk("B idle gap", owner(o_s_bready, o_s_rready, o_s_arid), 0);
    tick();
    chk("B owner read", owner(o_s_bready, o_s_rready, o_s_arid), 2);
    chk("B s_araddr", o_s_araddr, 32'h8000_0200);
    i_m1_arvalid = 1'b0;
    i_s_rvalid = 1'b1; i_s_rlast = 1'b1; i_s_rdata = 32'h0BAD_F00D; i_s_rid = 4'd2;
    #1;
    chk("B m1_rdata", o_m1_rdata, 32'h0BAD_F00D);
    tick();
    idle_inputs();

    // LSU read arrives while IFU waits five cycles for data: no preemption.
    i_m0_araddr = 32'h8000_0010; i_m0_arvalid = 1'b1;
    tick();
    tick();
    i_m0_arvalid = 1'b0;
    i_m1_araddr = 32'h8000_0020; i_m1_arvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("C wait%0d m1_arready", k), {31'd0, o_m1_arready}, 32'd0);
      tick();
    end
    i_s_rvalid = 1'b1; i_s_rlast = 1'b1; i_s_rid = 4'd1;
    #1;
    chk("C still ifu", owner(o_s_bready, o_s_rready, o_s_arid), 1);
    tick();
    i_s_rvalid = 1'b0; i_s_rlast = 1'b0;
    #1;
    chk("C idle m1_arready", {31'd0, o_m1_arready}, 32'd0);
    tick();
    chk("C lsu granted", {31'd0, o_m1_arready}, 32'd1);
    chk("C s_araddr", o_s_araddr, 32'h8000_0020);
    i_m1_arvalid = 1'b0; i_s_rvalid = 1'b1; i_s_rlast = 1'b1;
    tick();
    idle_inputs();

    // Reset during a write before the response; then a fresh IFU read.
    i_m1_awvalid = 1'b1; i_m1_wvalid = 1'b1; i_m1_wlast = 1'b1;
    tick();
    chk("D owner write", owner(o_s_bready, o_s_rready, o_s_arid), 3);
    tick();
    chk("D still write", owner(o_s_bready, o_s_rready, o_s_arid), 3);
    rst_n = 1'b0;
    tick();
    chk("D all outputs zero", {31'd0, any_out}, 32'd0);
    chk("D fair0 bready zero", {31'd0, z_s_bready}, 32'd0);
    idle_inputs();
    rst_n = 1'b1;
    i_m0_araddr = 32'h8000_0040; i_m0_arvalid = 1'b1;
    tick();
    chk("D ifu owner", owner(o_s_bready, o_s_rready, o_s_arid), 1);
    chk("D s_araddr", o_s_araddr, 32'h8000_0040);
    i_m0_arvalid = 1'b0;
    i_s_rdata = 32'hCAFE_F00D; i_s_rid = 4'd1; i_s_rvalid = 1'b1; i_s_rlast = 1'b1;
    #1;
    chk("D m0_rdata", o_m0_rdata, 32'hCAFE_F00D);
    tick();
    idle_inputs();
    #1;
    chk("D back to idle", owner(o_s_bready, o_s_rready, o_s_arid), 0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
